bnn_vote_accum: RTL

BNN_VOTE_ACCUM -- requirements
Module: bnn_vote_accum

---
 rtl/bnn_vote_accum.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/bnn_vote_accum.sv
// rtl/bnn_vote_accum.sv - windowed per-class vote accumulator with argmax scan; optional BNN_VOTE_TIE_FLAG_EN adds result_tie
module bnn_vote_accum #(
  parameter int NUM_CLASSES = 8,
  parameter int CNT_W       = 8,
  parameter int WINDOW      = 16,
  localparam int IDX_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   act_valid,
  input  logic [NUM_CLASSES-1:0] act,
  output logic                   act_ready,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [IDX_W-1:0]       result_class,
`ifdef BNN_VOTE_TIE_FLAG_EN
  output logic                   result_tie,
`endif
  output logic [CNT_W-1:0]       result_count
);

  typedef enum logic [1:0] {ACCUM, SCAN, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'(WINDOW - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NUM_CLASSES];
  logic [CNT_W-1:0] cnt_d [NUM_CLASSES];
  logic [CNT_W-1:0] samp_q, samp_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] best_cls_q, best_cls_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
  logic [IDX_W-1:0] res_cls_q, res_cls_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic [IDX_W-1:0] cand_cls;
  logic [CNT_W-1:0] cand_cnt;
`ifdef BNN_VOTE_TIE_FLAG_EN
  logic             tie_q, tie_d;
`endif

  // Next-state logic: accumulate votes, scan one counter per cycle, hold decision until taken
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    samp_d     = samp_q;
    idx_d      = idx_q;
    best_cls_d = best_cls_q;
    best_cnt_d = best_cnt_q;
    res_cls_d  = res_cls_q;
    res_cnt_d  = res_cnt_q;
`ifdef BNN_VOTE_TIE_FLAG_EN
    tie_d      = tie_q;
`endif
    // Index 0 seeds the running best; later indices only replace it on a strictly larger count
    if (idx_q == '0 || cnt_q[idx_q] > best_cnt_q) begin
      cand_cls = idx_q;
      cand_cnt = cnt_q[idx_q];
    end else begin
      cand_cls = best_cls_q;
      cand_cnt = best_cnt_q;
    end

    case (state_q)
      ACCUM: begin
        if (act_valid) begin
          for (int i = 0; i < NUM_CLASSES; i++) begin
            if (act[i] && cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
          samp_d = samp_q + CNT_W'(1);
          if (samp_q == LAST_SMP) begin
            state_d = SCAN;
            idx_d   = '0;
          end
        end
      end
      SCAN: begin
        best_cls_d = cand_cls;
        best_cnt_d = cand_cnt;
        idx_d      = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d   = HOLD;
          res_cls_d = cand_cls;
          res_cnt_d = cand_cnt;
`ifdef BNN_VOTE_TIE_FLAG_EN
          tie_d = 1'b0;
          for (int i = 0; i < NUM_CLASSES; i++) begin
            if (IDX_W'(i) != cand_cls && cnt_q[i] == cand_cnt) tie_d = 1'b1;
          end
`endif
        end
      end
      HOLD: begin
        if (result_ready) begin
          state_d = ACCUM;
          samp_d  = '0;
          for (int i = 0; i < NUM_CLASSES; i++) cnt_d[i] = '0;
`ifdef BNN_VOTE_TIE_FLAG_EN
          tie_d = 1'b0;
`endif
        end
      end
      default: state_d = ACCUM;
    endcase

    // Flush wins over any accept or handshake in the same cycle
    if (clear) begin
      state_d    = ACCUM;
      samp_d     = '0;
      idx_d      = '0;
      best_cls_d = '0;
      best_cnt_d = '0;
      res_cls_d  = '0;
      res_cnt_d  = '0;
      for (int i = 0; i < NUM_CLASSES; i++) cnt_d[i] = '0;
`ifdef BNN_VOTE_TIE_FLAG_EN
      tie_d = 1'b0;
`endif
    end
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ACCUM;
      samp_q     <= '0;
      idx_q      <= '0;
      best_cls_q <= '0;
      best_cnt_q <= '0;
      res_cls_q  <= '0;
      res_cnt_q  <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= '0;
`ifdef BNN_VOTE_TIE_FLAG_EN
      tie_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      samp_q     <= samp_d;
      idx_q      <= idx_d;
      best_cls_q <= best_cls_d;
      best_cnt_q <= best_cnt_d;
      res_cls_q  <= res_cls_d;
      res_cnt_q  <= res_cnt_d;
      for (int i = 0; i < NUM_CLASSES; i++) cnt_q[i] <= cnt_d[i];
`ifdef BNN_VOTE_TIE_FLAG_EN
      tie_q      <= tie_d;
`endif
    end
  end

  assign act_ready    = (state_q == ACCUM);
  assign result_valid = (state_q == HOLD);
  assign result_class = res_cls_q;
  assign result_count = res_cnt_q;
`ifdef BNN_VOTE_TIE_FLAG_EN
  assign result_tie   = tie_q;
`endif

endmodule
